state_action_table: RTL and testbench
=====================================

Name: state_action_table

Overview:
- Quadrature (incremental) encoder transition decoder for the encoder controller.
- Takes the previous and current sampled A/B phase pair as a 4-bit code and classifies the transition as increment, decrement, no-change or illegal.
- The result is a registered one-hot action word.
- Sits between the A/B input synchronizer/sampler and the position counter, which consumes the action bits.

Parameters:
- REVERSE_DIR, default 0: when 1, swaps the increment and decrement outputs, inverting the counting direction.
- OUT_REG, default 1: when 1, output_bus is registered (1-cycle latency); when 0, output_bus is the combinational table result and rst has no effect on it.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- input_bus  input  4  transition code {A_prev, B_prev, A_cur, B_cur}; bit3 = A_prev, bit0 = B_cur.
- output_bus  output  4  one-hot action: bit0 INC, bit1 DEC, bit2 NOCHG, bit3 ERR.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (OUT_REG=1): on a rising clk edge with rst=1, output_bus <= 4'b0000, meaning no action. rst has priority over the table.
- Normal operation (OUT_REG=1): on each rising clk edge with rst=0, output_bus <= TABLE(input_bus). Latency is exactly 1 cycle. No enable and no handshake; every edge samples.
- Forward phase sequence is 00 -> 01 -> 11 -> 10 -> 00, with the {A,B} pair ordered A then B.
- TABLE, REVERSE_DIR=0:
  - INC (4'b0001) for codes 1, 7, 14, 8.
  - DEC (4'b0010) for codes 2, 11, 13, 4.
  - NOCHG (4'b0100) for codes 0, 5, 10, 15.
  - ERR (4'b1000) for codes 3, 6, 9, 12 (both phases changed at once).
- REVERSE_DIR=1: the INC and DEC rows are exchanged. NOCHG and ERR rows are unchanged.
- Outside reset, exactly one output bit is set every cycle.
- Wrap-around transitions (10->00 and 00->10) are ordinary INC/DEC entries; there are no special cases.
- The block holds no history. Forming A_prev/B_prev is the upstream sampler's job. Back-to-back identical codes produce identical outputs each cycle.
- X/Z on input_bus: default branch drives ERR. The table is a full case; no latches.
- Reset asserted mid-stream: output is 0000 from the next edge. The first edge after rst deasserts loads TABLE(input_bus).

Decomposition:
- Shared package encoder_pkg holds:
  - Action constants ACT_NONE=4'b0000, ACT_INC=4'b0001, ACT_DEC=4'b0010, ACT_NOCHG=4'b0100, ACT_ERR=4'b1000.
  - Bit-index localparams for the four action bits.
  - The transition-code field positions.
  - A pure function decode_transition(code, reverse) returning the action word.
- One natural sub-module, quad_transition_lut: combinational 16-entry lookup with the REVERSE_DIR parameter.
- The top level adds the optional output register and the reset logic.

Test Plan:
- Reset: rst=1 for 2 edges with input_bus=4'd7 -> output_bus=4'b0000. Release rst; next edge -> 4'b0001.
- Full sweep, REVERSE_DIR=0: apply input_bus 0..15 one per clock. Each value checked one edge later:
  - Code 0 -> 0100; 1 -> 0001; 2 -> 0010; 3 -> 1000.
  - Code 4 -> 0010; 5 -> 0100; 6 -> 1000; 7 -> 0001.
  - Code 8 -> 0001; 9 -> 1000; 10 -> 0100; 11 -> 0010.
  - Code 12 -> 1000; 13 -> 0010; 14 -> 0001; 15 -> 0100.
- Full sweep, REVERSE_DIR=1: same stimulus. Codes 1, 7, 14, 8 -> 0010; codes 2, 11, 13, 4 -> 0001; other codes as above.
- Rotation sequence: feed the forward chain of codes 1, 7, 14, 8, repeated 3 times -> 12 consecutive INC pulses. The reverse chain 2, 11, 13, 4 -> 12 DEC pulses.
- Latency/reset mid-stream:
  - Change input_bus between edges -> output changes only at the next edge.
  - Assert rst during the sweep at code 9 -> 0000 at that edge. Resume with code 10 -> 0100.
- One-hot property: random input_bus for 1000 cycles with rst=0 -> $onehot(output_bus) holds every cycle.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared encoder definitions: action encodings, bit positions within the
// transition code and action word, and the transition decode function.
package encoder_pkg;

    // One-hot action words driven towards the position counter
    localparam logic [3:0] ACT_NONE  = 4'b0000;
    localparam logic [3:0] ACT_INC   = 4'b0001;
    localparam logic [3:0] ACT_DEC   = 4'b0010;
    localparam logic [3:0] ACT_NOCHG = 4'b0100;
    localparam logic [3:0] ACT_ERR   = 4'b1000;

    // Bit positions inside the action word
    localparam int unsigned INC_BIT   = 0;
    localparam int unsigned DEC_BIT   = 1;
    localparam int unsigned NOCHG_BIT = 2;
    localparam int unsigned ERR_BIT   = 3;

    // Field positions inside the transition code {A_prev, B_prev, A_cur, B_cur}
    localparam int unsigned A_PREV_BIT = 3;
    localparam int unsigned B_PREV_BIT = 2;
    localparam int unsigned A_CUR_BIT  = 1;
    localparam int unsigned B_CUR_BIT  = 0;

    // Classify a previous/current phase pair; forward order is 00->01->11->10->00.
    function automatic logic [3:0] decode_transition(input logic [3:0] code,
                                                     input logic       reverse);
        logic [3:0] act;
        case (code)
            4'd1, 4'd7, 4'd14, 4'd8:  act = ACT_INC;
            4'd2, 4'd11, 4'd13, 4'd4: act = ACT_DEC;
            4'd0, 4'd5, 4'd10, 4'd15: act = ACT_NOCHG;
            // Both phases moved at once (3, 6, 9, 12) or the code is not a
            // clean binary value: flag as illegal.
            default:                  act = ACT_ERR;
        endcase
        if (reverse && (act == ACT_INC || act == ACT_DEC)) begin
            act = {act[ERR_BIT], act[NOCHG_BIT], act[INC_BIT], act[DEC_BIT]};
        end
        return act;
    endfunction

endpackage

// File: rtl/quad_transition_lut.sv
// Combinational 16-entry quadrature transition lookup.
module quad_transition_lut
    import encoder_pkg::*;
#(
    parameter int unsigned REVERSE_DIR = 0
) (
    input  logic [3:0] code,
    output logic [3:0] action
);

    // Table lookup; direction swap is resolved at elaboration time
    always_comb begin
        action = decode_transition(code, REVERSE_DIR != 0);
    end

endmodule

// File: rtl/state_action_table.sv
// Quadrature encoder transition decoder: classifies {A_prev,B_prev,A_cur,B_cur}
// into a one-hot INC/DEC/NOCHG/ERR action word, optionally registered.
module state_action_table
    import encoder_pkg::*;
#(
    parameter int unsigned REVERSE_DIR = 0,
    parameter int unsigned OUT_REG     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] input_bus,
    output logic [3:0] output_bus
);

    logic [3:0] lut_action;

    quad_transition_lut #(
        .REVERSE_DIR(REVERSE_DIR)
    ) u_lut (
        .code  (input_bus),
        .action(lut_action)
    );

    generate
        if (OUT_REG != 0) begin : g_reg
            // Register the action word; reset forces "no action"
            always_ff @(posedge clk) begin
                if (rst) begin
                    output_bus <= ACT_NONE;
                end else begin
                    output_bus <= lut_action;
                end
            end
        end else begin : g_comb
            assign output_bus = lut_action;
        end
    endgenerate

endmodule

// File: tb/tb_state_action_table.sv
// Self-checking bench for state_action_table: forward, reversed and
// combinational variants checked against a phase-position reference model.
module tb_state_action_table;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] input_bus = 4'd7;
    logic [3:0] out_fwd;
    logic [3:0] out_rev;
    logic [3:0] out_comb;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [3:0] prev_fwd;
    logic [3:0] prev_rev;
    bit         have_prev = 1'b0;

    always #5 clk = ~clk;

    state_action_table #(.REVERSE_DIR(0), .OUT_REG(1)) u_fwd (
        .clk(clk), .rst(rst), .input_bus(input_bus), .output_bus(out_fwd)
    );

    state_action_table #(.REVERSE_DIR(1), .OUT_REG(1)) u_rev (
        .clk(clk), .rst(rst), .input_bus(input_bus), .output_bus(out_rev)
    );

    state_action_table #(.REVERSE_DIR(0), .OUT_REG(0)) u_comb (
        .clk(clk), .rst(rst), .input_bus(input_bus), .output_bus(out_comb)
    );

    // Position of an {A,B} pair along the forward cycle 00,01,11,10
    function automatic int unsigned phase_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Reference: step distance around the cycle decides the action
    function automatic logic [3:0] model(input logic [3:0] code, input bit rev);
        logic [1:0]  prev_ab;
        logic [1:0]  cur_ab;
        int unsigned step;
        prev_ab = code[3:2];
        cur_ab  = code[1:0];
        step = (phase_pos(cur_ab) + 4 - phase_pos(prev_ab)) % 4;
        case (step)
            0:       return 4'b0100;
            1:       return rev ? 4'b0010 : 4'b0001;
            3:       return rev ? 4'b0001 : 4'b0010;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one code (and rst) between edges, then check the registered result
    task automatic apply(input logic [3:0] code, input logic r);
        logic [3:0] exp_f;
        logic [3:0] exp_r;
        @(negedge clk);
        input_bus = code;
        rst       = r;
        #1;
        check("comb", out_comb, model(code, 1'b0));
        if (have_prev) begin
            check("hold_fwd", out_fwd, prev_fwd);
            check("hold_rev", out_rev, prev_rev);
        end
        @(posedge clk);
        #1;
        exp_f = r ? 4'b0000 : model(code, 1'b0);
        exp_r = r ? 4'b0000 : model(code, 1'b1);
        check($sformatf("fwd code=%0d rst=%0b", code, r), out_fwd, exp_f);
        check($sformatf("rev code=%0d rst=%0b", code, r), out_rev, exp_r);
        prev_fwd  = exp_f;
        prev_rev  = exp_r;
        have_prev = 1'b1;
    endtask

    initial begin
        logic [3:0] fwd_chain [4];
        logic [3:0] rev_chain [4];
        logic [3:0] rnd;
        fwd_chain = '{4'd1, 4'd7, 4'd14, 4'd8};
        rev_chain = '{4'd2, 4'd11, 4'd13, 4'd4};

        // Reset with code 7 held, then release
        apply(4'd7, 1'b1);
        apply(4'd7, 1'b1);
        check("reset_fwd", out_fwd, 4'b0000);
        apply(4'd7, 1'b0);
        check("post_reset", out_fwd, 4'b0001);

        // Full sweep, both directions in parallel
        for (int i = 0; i < 16; i++) apply(4'(i), 1'b0);

        // Rotation chains
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 4; j++) begin
                apply(fwd_chain[j], 1'b0);
                check("rot_inc", out_fwd, 4'b0001);
            end
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 4; j++) begin
                apply(rev_chain[j], 1'b0);
                check("rot_dec", out_fwd, 4'b0010);
            end

        // Reset mid-sweep at code 9, resume at code 10
        for (int i = 0; i < 9; i++) apply(4'(i), 1'b0);
        apply(4'd9, 1'b1);
        check("mid_reset", out_fwd, 4'b0000);
        apply(4'd10, 1'b0);
        check("resume", out_fwd, 4'b0100);

        // Random codes: model agreement plus one-hot every cycle
        for (int n = 0; n < 1000; n++) begin
            rnd = 4'($urandom_range(0, 15));
            apply(rnd, 1'b0);
            check("onehot_fwd", {3'b000, $onehot(out_fwd)}, 4'b0001);
            check("onehot_rev", {3'b000, $onehot(out_rev)}, 4'b0001);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
